mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data/instruction RAM between the instruction fetch path, the load/store path, and an external requester (I/O or display scan-out).
- Accepts one transaction at a time, sequences the memory access, waits out the RAM read latency, and returns a response pulse to the winning requester.
- Sits between the multicycle processor core and the RAM. The core holds its fetch or LOAD state until it sees rsp_valid.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter_rr_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter and the core.
// Holds the arbiter state encoding, requester indices and default widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_EXT   = 2;

    localparam int DEF_NREQ = 3;
    localparam int DEF_AW   = 16;
    localparam int DEF_DW   = 16;

    // Width of an index into n requesters (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// ptr is expected to stay below NREQ.
import mem_arb_pkg::*;

module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    // Scan ptr, ptr+1, ... modulo NREQ and stop at the first hit.
    always_comb begin
        int i;
        i      = 0;
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            i = (int'(ptr) + k) % NREQ;
            if (!any && req[i]) begin
                any       = 1'b1;
                idx       = PW'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch, load/store and an external requester.
// Build option: ARB_DATA_PRIORITY_EN gives requester 1 absolute priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy
);

    localparam int PW = ptr_width(NREQ);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t      state;
    logic [PW-1:0]   rr_ptr;
    logic [LW-1:0]   lat_cnt;
    logic [NREQ-1:0] win_oh;

    logic [NREQ-1:0] pick_req;
    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;

    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic            keep_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (pick_req),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

`ifdef ARB_DATA_PRIORITY_EN
    logic data_hit;

    assign data_hit  = req_valid[REQ_DATA];
    assign pick_req  = req_valid & ~(NREQ'(1) << REQ_DATA);
    assign grant_any = data_hit | pick_any;
    assign grant_idx = data_hit ? PW'(REQ_DATA) : pick_idx;
    assign grant_oh  = data_hit ? (NREQ'(1) << REQ_DATA) : pick_oh;
    assign keep_ptr  = data_hit;
`else
    assign pick_req  = req_valid;
    assign grant_any = pick_any;
    assign grant_idx = pick_idx;
    assign grant_oh  = pick_oh;
    assign keep_ptr  = 1'b0;
`endif

    assign req_ready = (state == IDLE) ? grant_oh : '0;
    assign busy      = (state != IDLE);

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
        return (w == PW'(NREQ - 1)) ? '0 : w + 1'b1;
    endfunction

    // Transaction sequencer; mem_addr/mem_wdata double as the payload latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lat_cnt   <= '0;
            win_oh    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        win_oh    <= grant_oh;
                        mem_en    <= 1'b1;
                        mem_we    <= req_we[grant_idx];
                        mem_addr  <= req_addr[grant_idx*AW +: AW];
                        mem_wdata <= req_wdata[grant_idx*DW +: DW];
                        if (!keep_ptr)
                            rr_ptr <= ptr_after(grant_idx);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        rsp_valid <= win_oh;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= LW'(MEM_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= win_oh;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Handshake invariants: grants and completions never overlap requesters.
    a_ready_oh: assert property (
        @(posedge clk) disable iff (!rst) $onehot0(req_ready));
    a_rsp_oh: assert property (
        @(posedge clk) disable iff (!rst) $onehot0(rsp_valid));
    a_ready_idle: assert property (
        @(posedge clk) disable iff (!rst) (state != IDLE) |-> (req_ready == '0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM model.
// Directed vectors, corner sequences and a randomized reference-model run.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ    = 3;
    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_we, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_en, mem_we, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Behavioural RAM: contents default to a pattern until written.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : {~a[7:0], a[7:0]};
    endfunction

    logic [DW-1:0] ram [0:255];
    logic [255:0]  ram_wr;
    logic          tb_clear;
    logic [DW-1:0] rd_pipe [0:MEM_LAT-1];

    function automatic logic [15:0] ram_rd(input logic [7:0] a);
        return ram_wr[a] ? ram[a] : init_val({8'h00, a});
    endfunction

    always @(posedge clk) begin
        if (tb_clear)
            ram_wr <= '0;
        else if (mem_en && mem_we) begin
            ram[mem_addr[7:0]]    <= mem_wdata;
            ram_wr[mem_addr[7:0]] <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? ram_rd(mem_addr[7:0]) : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no-event expected event", name);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
        req_we[i]            = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  exp_ready;
        logic [15:0] exp_rdata;
    } vec_t;

    // Reference model state for the randomized run.
    bit          pend [3];
    logic        we_m [3];
    logic [2:0]  k_m [3];
    logic [15:0] data_m [3];
    logic [15:0] ref_mem [8];
    int          ptr_m;

    function automatic int model_pick();
`ifdef ARB_DATA_PRIORITY_EN
        if (pend[1]) return 1;
`endif
        for (int k = 0; k < 3; k++)
            if (pend[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
        return -1;
    endfunction

    initial begin
        vec_t tbl [12];
        int   grants [6];
        int   n, cnt, ready_seen, rsp_seen;

        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tb_clear = 1'b1;
        rst = 1'b0;
        tick;
        tick;
        tb_clear = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        rst = 1'b1;
        #1 chk("rst_ready", req_ready, 0);

        // Single write from requester 2.
        set_req(2, 1'b1, 16'h0040, 16'hBEEF);
        req_valid = 3'b100;
        #1 chk("wr_ready", req_ready, 3'b100);
        tick;
        req_valid = '0;
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 16'h0040);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
        chk("wr_busy", busy, 1);
        tick;
        chk("wr_rsp", rsp_valid, 3'b100);
        chk("wr_mem_en_off", mem_en, 0);
        tick;
        chk("wr_idle", busy, 0);

        // Single read from requester 0, MEM_LAT=2.
        set_req(0, 1'b0, 16'h0010, 16'h0000);
        req_valid = 3'b001;
        #1 chk("rd_ready", req_ready, 3'b001);
        tick;
        req_valid = '0;
        chk("rd_mem_en_t1", mem_en, 1);
        chk("rd_mem_we_t1", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 16'h0010);
        tick;
        chk("rd_mem_en_t2", mem_en, 0);
        chk("rd_rsp_t2", rsp_valid, 0);
        tick;
        chk("rd_mem_en_t3", mem_en, 0);
        chk("rd_rsp_t3", rsp_valid, 0);
        tick;
        chk("rd_rsp_t4", rsp_valid, 3'b001);
        chk("rd_rdata", rsp_rdata, 16'h1234);
        tick;

        // Requester 1 pulses once while a write is in flight.
        set_req(0, 1'b1, 16'h0030, 16'h5555);
        req_valid = 3'b001;
        #1 chk("pulse_first_ready", req_ready, 3'b001);
        tick;
        set_req(1, 1'b0, 16'h0031, 16'h0000);
        req_valid = 3'b010;
        cnt = mem_en ? 1 : 0;
        #1 ready_seen = (req_ready != 0) ? 1 : 0;
        tick;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (req_ready != 0) ready_seen = 1;
            if (mem_en) cnt++;
            tick;
        end
        chk("pulse_no_grant", ready_seen, 0);
        chk("pulse_one_access", cnt, 1);

`ifndef ARB_DATA_PRIORITY_EN
        // Table of isolated transactions from a fresh reset (rr_ptr=0).
        tbl[0]  = '{3'b111, 1'b1, 16'h0020, 16'hA5A5, 3'b001, 16'h0000};
        tbl[1]  = '{3'b111, 1'b0, 16'h0020, 16'h0000, 3'b010, 16'hA5A5};
        tbl[2]  = '{3'b111, 1'b0, 16'h0040, 16'h0000, 3'b100, 16'hBEEF};
        tbl[3]  = '{3'b111, 1'b1, 16'h0021, 16'h1111, 3'b001, 16'h0000};
        tbl[4]  = '{3'b111, 1'b0, 16'h0021, 16'h0000, 3'b010, 16'h1111};
        tbl[5]  = '{3'b111, 1'b0, 16'h0030, 16'h0000, 3'b100, 16'h5555};
        tbl[6]  = '{3'b110, 1'b0, 16'h0010, 16'h0000, 3'b010, 16'h1234};
        tbl[7]  = '{3'b011, 1'b1, 16'h0022, 16'h7777, 3'b001, 16'h0000};
        tbl[8]  = '{3'b100, 1'b0, 16'h0022, 16'h0000, 3'b100, 16'h7777};
        tbl[9]  = '{3'b000, 1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000};
        tbl[10] = '{3'b101, 1'b0, 16'h0021, 16'h0000, 3'b001, 16'h1111};
        tbl[11] = '{3'b101, 1'b0, 16'h0020, 16'h0000, 3'b100, 16'hA5A5};
        do_reset;
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < 3; i++)
                set_req(i, tbl[j].we, tbl[j].addr, tbl[j].wdata);
            req_valid = tbl[j].valid;
            #1 chk($sformatf("tbl%0d_ready", j), req_ready, tbl[j].exp_ready);
            tick;
            req_valid = '0;
            if (tbl[j].exp_ready != 0) begin
                for (int k = 0; k < 10 && rsp_valid == 0; k++)
                    tick;
                chk($sformatf("tbl%0d_rsp", j), rsp_valid, tbl[j].exp_ready);
                if (!tbl[j].we)
                    chk($sformatf("tbl%0d_rdata", j), rsp_rdata, tbl[j].exp_rdata);
                tick;
            end
        end

        // All three hold read requests continuously from reset.
        do_reset;
        for (int i = 0; i < 3; i++)
            set_req(i, 1'b0, 16'h0010, 16'h0000);
        req_valid = 3'b111;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            #1;
            if (req_ready != 0) begin
                chk("cont_onehot", $onehot(req_ready), 1);
                for (int i = 0; i < 3; i++)
                    if (req_ready[i]) grants[n] = i;
                n++;
            end
            tick;
        end
        req_valid = '0;
        if (n < 6) fail("cont_grant_count");
        for (int i = 0; i < n; i++)
            chk($sformatf("cont_grant%0d", i), grants[i], i % 3);
        repeat (8) tick;
`endif

        // Reset in WAIT of a read by requester 1 abandons it.
        do_reset;
        set_req(1, 1'b0, 16'h0010, 16'h0000);
        req_valid = 3'b010;
        #1 chk("rstw_ready", req_ready, 3'b010);
        tick;
        req_valid = '0;
        tick;
        chk("rstw_in_wait", busy, 1);
        rst = 1'b0;
        tick;
        chk("rstw_busy", busy, 0);
        chk("rstw_mem_en", mem_en, 0);
        chk("rstw_rsp", rsp_valid, 0);
        rst = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid != 0) rsp_seen = 1;
            tick;
        end
        chk("rstw_no_rsp", rsp_seen, 0);
        for (int i = 0; i < 3; i++)
            set_req(i, 1'b0, 16'h0010, 16'h0000);
        req_valid = 3'b111;
`ifdef ARB_DATA_PRIORITY_EN
        #1 chk("rstw_next_grant", req_ready, 3'b010);
`else
        #1 chk("rstw_next_grant", req_ready, 3'b001);
`endif
        tick;
        req_valid = '0;
        repeat (8) tick;

`ifdef ARB_DATA_PRIORITY_EN
        // Data requester starves fetch while it keeps asking.
        do_reset;
        set_req(0, 1'b0, 16'h0010, 16'h0000);
        set_req(1, 1'b0, 16'h0010, 16'h0000);
        req_valid = 3'b011;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            #1;
            if (req_ready != 0) begin
                chk($sformatf("prio_grant%0d", n), req_ready, 3'b010);
                n++;
            end
            tick;
        end
        if (n < 4) fail("prio_grant_count");
        req_valid = 3'b001;
        n = 0;
        for (int c = 0; c < 12 && n == 0; c++) begin
            #1;
            if (req_ready != 0) begin
                chk("prio_fetch_after_drop", req_ready, 3'b001);
                n++;
            end
            tick;
        end
        if (n == 0) fail("prio_fetch_after_drop");
        req_valid = '0;
        repeat (8) tick;
`endif

        // Randomized traffic against the reference model.
        do_reset;
        ptr_m = 0;
        for (int i = 0; i < 3; i++) pend[i] = 0;
        for (int k = 0; k < 8; k++) ref_mem[k] = ram_rd(8'h50 + 8'(k));
        begin
            bit          in_txn, done;
            int          cur_w, cur_start, exp_w;
            bit          cur_we;
            logic [15:0] cur_exp;
            in_txn = 0; cur_w = 0; cur_start = 0; cur_we = 0; cur_exp = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                done = 0;
                if (rsp_valid != 0) begin
                    if (!in_txn) fail("rnd_spurious_rsp");
                    else begin
                        chk("rnd_rsp_idx", rsp_valid, 32'(1) << cur_w);
                        chk("rnd_latency", cyc - cur_start,
                            cur_we ? 2 : 2 + MEM_LAT);
                        if (!cur_we) chk("rnd_rdata", rsp_rdata, cur_exp);
                    end
                    done = 1;
                end
                chk("rnd_busy", busy, in_txn);
                for (int i = 0; i < 3; i++) begin
                    if (pend[i] && $urandom_range(0, 15) == 0)
                        pend[i] = 0;
                    else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i]   = 1;
                        we_m[i]   = 1'($urandom_range(0, 1));
                        k_m[i]    = 3'($urandom_range(0, 7));
                        data_m[i] = 16'($urandom);
                    end
                    if (pend[i])
                        set_req(i, we_m[i], 16'h0050 + 16'(k_m[i]), data_m[i]);
                    else
                        set_req(i, 1'($urandom), 16'($urandom), 16'($urandom));
                    req_valid[i] = pend[i];
                end
                #1;
                exp_w = in_txn ? -1 : model_pick();
                chk("rnd_ready", req_ready, (exp_w < 0) ? 0 : 32'(1) << exp_w);
                if (exp_w >= 0) begin
                    pend[exp_w] = 0;
                    in_txn    = 1;
                    cur_w     = exp_w;
                    cur_start = cyc;
                    cur_we    = we_m[exp_w];
                    if (cur_we) ref_mem[k_m[exp_w]] = data_m[exp_w];
                    else cur_exp = ref_mem[k_m[exp_w]];
`ifdef ARB_DATA_PRIORITY_EN
                    if (exp_w != 1) ptr_m = (exp_w + 1) % 3;
`else
                    ptr_m = (exp_w + 1) % 3;
`endif
                end
                if (done) in_txn = 0;
                if (in_txn && cyc - cur_start > 12) begin
                    fail("rnd_timeout");
                    in_txn = 0;
                end
                tick;
            end
        end
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
